button_event_gen: RTL and testbench
===================================

Name: button_event_gen

Overview:
- Sits directly downstream of the push-button debouncer.
- Consumes the debounced button level and turns it into single-cycle user-interface events: press, release, long-press and auto-repeat.
- Also provides a held level and a running press counter.
- The VGA mode/colour control logic uses these events to step settings: once per tap, or continuously while the button is held.

Parameters:
HOLD_CYCLES, 25_000_000, clk cycles from press pulse to long_press pulse (0.5 s at 50 MHz); must be >= 2
REPEAT_CYCLES, 5_000_000, clk cycles between auto-repeat pulses while held; must be >= 2
CNT_W, 25, hold/repeat counter width; must represent max(HOLD_CYCLES, REPEAT_CYCLES)-1
REPEAT_EN, 1, 1 = generate repeat pulses; 0 = repeat tied low

Ports:
clk  input  1  system clock; all state updates on posedge clk
clr  input  1  asynchronous, active-high reset
btn_in  input  1  debounced button level (1 = pressed); treated as asynchronous
press  output  1  one-cycle pulse on a new press
release  output  1  one-cycle pulse on release
long_press  output  1  one-cycle pulse when hold reaches HOLD_CYCLES
repeat  output  1  one-cycle auto-repeat pulse
held  output  1  high while the FSM is in PRESS or HOLD
press_count  output  8  count of press pulses; wraps 255 -> 0

Behaviour:
- Reset (clr high, asynchronous):
  - s1, s2 (synchroniser flops) = 0; state = IDLE; cnt = 0.
  - press, release, long_press, repeat, held = 0; press_count = 0.
  - All outputs are registered and go to 0 immediately on clr.
- Synchroniser: 2-flop, s1 <= btn_in, s2 <= s1. The FSM uses only s2.
- FSM states: IDLE, PRESS, HOLD. Every pulse output defaults to 0 each cycle.
- IDLE:
  - If s2 = 1: go to PRESS, cnt <= 0, press <= 1, press_count <= press_count + 1.
  - Otherwise stay in IDLE.
- PRESS:
  - If s2 = 0: go to IDLE, release <= 1, cnt <= 0.
  - Else if cnt = HOLD_CYCLES-1: go to HOLD, long_press <= 1, repeat <= REPEAT_EN, cnt <= 0.
  - Else: cnt <= cnt + 1.
- HOLD:
  - If s2 = 0: go to IDLE, release <= 1, cnt <= 0.
  - Else if cnt = REPEAT_CYCLES-1: repeat <= REPEAT_EN, cnt <= 0.
  - Else: cnt <= cnt + 1.
- held <= 1 when the next state is PRESS or HOLD, else 0. It rises in the same cycle as press and falls in the same cycle as release.
- Latency, with btn_in first sampled high at edge E0:
  - s2 = 1 after E1; press is high from E2 to E3.
  - long_press is high HOLD_CYCLES cycles after press.
  - Later repeats follow every REPEAT_CYCLES cycles.
  - release is high 3 edges after btn_in is first sampled low.
- Priority: release beats repeat and long_press in the same cycle. When s2 falls, no other pulse fires that cycle.
- Coincident pulses: long_press and repeat coincide on the first repeat. No other pair of pulses is ever high together.
- Short taps: a press shorter than HOLD_CYCLES produces press then release only. The minimum detectable pulse is whatever survives the synchroniser.
- press_count: 8-bit unsigned, increments only on a press pulse, modulo 256.
- Reset mid-operation:
  - All state is cleared; no release pulse is emitted.
  - If btn_in is still high after clr deasserts, a fresh press is generated after the normal 3-edge latency, because s2 restarts from 0.
- Counter wrap: cnt never exceeds max(HOLD_CYCLES, REPEAT_CYCLES)-1. There is no overflow path.

Test Plan:
(All with HOLD_CYCLES=8, REPEAT_CYCLES=4, REPEAT_EN=1; edges numbered from btn_in first sampled high = E0.)
- Reset: assert clr mid-cycle with btn_in=1 -> all outputs 0 immediately; after release of clr, press pulses 3 edges later; press_count=1.
- Short tap: btn_in high for 5 cycles (E0–E4) -> press high E2–E3, release high E7–E8, no long_press/repeat, held high E2–E7, press_count=1.
- Long hold: btn_in high 30 cycles (E0–E29) -> press at E2; long_press+repeat at E10; repeat at E14, E18, E22, E26, E30 (6 repeats total); release at E32; long_press exactly once.
- REPEAT_EN=0, same 30-cycle hold -> long_press at E10, repeat never asserted, release at E32.
- Release/repeat collision: drop btn_in so that s2 falls exactly when cnt=REPEAT_CYCLES-1 in HOLD -> release=1, repeat=0 that cycle, state IDLE.
- Counter wrap: 256 short taps (each 3 high / 3 low) -> exactly 256 press and 256 release pulses; press_count ends at 0.

Source files
------------

// File: rtl/button_event_gen_if.sv
// Button-side bundle for button_event_gen: debounced level in, UI events out.
// The button source is the master; the event generator is the slave.
interface button_event_gen_if;
    logic       btn_i;
    logic       press_o;
    logic       release_o;
    logic       long_press_o;
    logic       repeat_o;
    logic       held_o;
    logic [7:0] press_count_o;

    modport master (
        output btn_i,
        input  press_o,
        input  release_o,
        input  long_press_o,
        input  repeat_o,
        input  held_o,
        input  press_count_o
    );

    modport slave (
        input  btn_i,
        output press_o,
        output release_o,
        output long_press_o,
        output repeat_o,
        output held_o,
        output press_count_o
    );
endinterface

// File: rtl/button_event_gen.sv
// Turns a debounced button level into one-cycle press/release/long-press/repeat
// events, plus a held level and a wrapping 8-bit press counter.
module button_event_gen #(
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000,
    parameter int CNT_W         = 25,
    parameter int REPEAT_EN     = 1
) (
    input  logic                 clk,
    input  logic                 clr,
    button_event_gen_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic             REPEAT_BIT  = (REPEAT_EN != 0);

    logic             s1_q, s2_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_press_q, long_press_d;
    logic             repeat_q, repeat_d;
    logic             held_q, held_d;
    logic [7:0]       count_q, count_d;

    // The button is asynchronous to clk; only s2_q may feed the FSM.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours, which keeps the two-stage chain intact.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= bus.btn_i;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_press_q <= 1'b0;
            repeat_q     <= 1'b0;
            held_q       <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            press_q      <= press_d;
            release_q    <= release_d;
            long_press_q <= long_press_d;
            repeat_q     <= repeat_d;
            held_q       <= held_d;
            count_q      <= count_d;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can
        // leave it unassigned and infer a latch; pulses default low each cycle.
        state_d      = state_q;
        cnt_d        = cnt_q;
        count_d      = count_q;
        press_d      = 1'b0;
        release_d    = 1'b0;
        long_press_d = 1'b0;
        repeat_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (s2_q) begin
                    state_d = ST_PRESS;
                    cnt_d   = '0;
                    press_d = 1'b1;
                    count_d = count_q + 8'd1;
                end
            end
            // Release is tested first so it always beats long-press/repeat.
            ST_PRESS: begin
                if (!s2_q) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d      = ST_HOLD;
                    long_press_d = 1'b1;
                    repeat_d     = REPEAT_BIT;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (!s2_q) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else if (cnt_q == REPEAT_LAST) begin
                    repeat_d = REPEAT_BIT;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d == ST_PRESS) || (state_d == ST_HOLD);
    end

    assign bus.press_o       = press_q;
    assign bus.release_o     = release_q;
    assign bus.long_press_o  = long_press_q;
    assign bus.repeat_o      = repeat_q;
    assign bus.held_o        = held_q;
    assign bus.press_count_o = count_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Scoreboard bench for button_event_gen: a level-history reference model queues
// expected events; a negedge monitor pops and compares whenever a DUT pulses.
module tb_button_event_gen;

    localparam int HOLD   = 8;
    localparam int REPEAT = 4;

    typedef struct {
        int         cyc;
        logic [3:0] pulses;   // {press, release, long_press, repeat}
        logic [7:0] cnt;
        logic       held;
    } ev_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic btn = 1'b0;

    always #5 clk = ~clk;

    button_event_gen_if ifa ();
    button_event_gen_if ifb ();
    assign ifa.btn_i = btn;
    assign ifb.btn_i = btn;

    button_event_gen #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPEAT), .CNT_W(4), .REPEAT_EN(1))
        dut_a (.clk(clk), .clr(clr), .bus(ifa.slave));
    button_event_gen #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPEAT), .CNT_W(4), .REPEAT_EN(0))
        dut_b (.clk(clk), .clr(clr), .bus(ifb.slave));

    int nchecks = 0;
    int nerrors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the FSM sees the button level two samples late; events
    // follow from edges of that delayed level and the time since its rise.
    int   cyc = 0;
    bit   lvl[$];
    int   press_at = 0;
    int   mcount = 0;
    ev_t  qa[$];
    ev_t  qb[$];

    always @(posedge clk) begin
        int  n, k;
        bit  cur, prev, p, r, l, rp;
        cyc++;
        if (clr) begin
            lvl.delete();
            mcount = 0;
        end else begin
            lvl.push_back(btn);
            n    = lvl.size() - 1;
            cur  = (n >= 2) ? lvl[n-2] : 1'b0;
            prev = (n >= 3) ? lvl[n-3] : 1'b0;
            p = 0; r = 0; l = 0; rp = 0;
            if (cur && !prev) begin
                p        = 1;
                press_at = n;
                mcount   = (mcount + 1) % 256;
            end else if (!cur && prev) begin
                r = 1;
            end else if (cur) begin
                k  = n - press_at;
                l  = (k == HOLD);
                rp = (k >= HOLD) && ((k - HOLD) % REPEAT == 0);
            end
            if (p || r || l || rp)
                qa.push_back('{cyc, {p, r, l, rp}, 8'(mcount), cur});
            if (p || r || l)
                qb.push_back('{cyc, {p, r, l, 1'b0}, 8'(mcount), cur});
        end
    end

    int npress[2], nrel[2], nlong[2], nrep[2];

    task automatic compare(input string who, input ev_t e, input logic [3:0] obs,
                           input logic [7:0] cnt, input logic held);
        check({who, " event cycle"}, cyc, e.cyc);
        check({who, " pulses"}, obs, e.pulses);
        check({who, " press_count"}, cnt, e.cnt);
        check({who, " held"}, held, e.held);
    endtask

    always @(negedge clk) begin
        logic [3:0] oa, ob;
        ev_t e;
        if (!clr) begin
            oa = {ifa.press_o, ifa.release_o, ifa.long_press_o, ifa.repeat_o};
            ob = {ifb.press_o, ifb.release_o, ifb.long_press_o, ifb.repeat_o};
            if (oa != 4'd0) begin
                npress[0] += oa[3]; nrel[0] += oa[2]; nlong[0] += oa[1]; nrep[0] += oa[0];
                if (qa.size() == 0) check("dut_a unexpected pulse", oa, 0);
                else begin
                    e = qa.pop_front();
                    compare("dut_a", e, oa, ifa.press_count_o, ifa.held_o);
                end
            end
            if (ob != 4'd0) begin
                npress[1] += ob[3]; nrel[1] += ob[2]; nlong[1] += ob[1]; nrep[1] += ob[0];
                if (qb.size() == 0) check("dut_b unexpected pulse", ob, 0);
                else begin
                    e = qb.pop_front();
                    compare("dut_b", e, ob, ifb.press_count_o, ifb.held_o);
                end
            end
        end
    end

    // Holds btn at v for n cycles; always entered and left on a negedge.
    task automatic drive(input bit v, input int n);
        btn = v;
        repeat (n) @(negedge clk);
    endtask

    int s_press[2], s_rel[2], s_long[2], s_rep[2];

    task automatic snap();
        for (int i = 0; i < 2; i++) begin
            s_press[i] = npress[i]; s_rel[i] = nrel[i];
            s_long[i]  = nlong[i];  s_rep[i] = nrep[i];
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset press_count", ifa.press_count_o, 0);
        check("reset held", ifa.held_o, 0);
        clr = 1'b0;
        drive(0, 4);

        // Short tap: 5 high cycles -> press and release only.
        snap();
        drive(1, 5);
        drive(0, 10);
        check("tap press count", npress[0] - s_press[0], 1);
        check("tap release count", nrel[0] - s_rel[0], 1);
        check("tap long count", nlong[0] - s_long[0], 0);
        check("tap repeat count", nrep[0] - s_rep[0], 0);
        check("tap press_count", ifa.press_count_o, 1);

        // Long hold: 30 high cycles.
        snap();
        drive(1, 30);
        drive(0, 10);
        check("hold long count a", nlong[0] - s_long[0], 1);
        check("hold repeat count a", nrep[0] - s_rep[0], 6);
        check("hold long count b", nlong[1] - s_long[1], 1);
        check("hold repeat count b", nrep[1] - s_rep[1], 0);
        check("hold release count", nrel[0] - s_rel[0], 1);

        // Release lands exactly on the second repeat slot.
        snap();
        drive(1, 12);
        drive(0, 10);
        check("collision repeat count", nrep[0] - s_rep[0], 1);
        check("collision release count", nrel[0] - s_rel[0], 1);
        check("collision held after", ifa.held_o, 0);

        // Randomised bursts, including single-cycle blips.
        for (int i = 0; i < 40; i++) begin
            drive(1, $urandom_range(1, 40));
            drive(0, $urandom_range(1, 10));
        end
        drive(0, 6);

        // Asynchronous reset mid-hold.
        snap();
        drive(1, 15);
        #2 clr = 1'b1;
        #1;
        check("clr async press", ifa.press_o, 0);
        check("clr async release", ifa.release_o, 0);
        check("clr async long", ifa.long_press_o, 0);
        check("clr async repeat", ifa.repeat_o, 0);
        check("clr async held", ifa.held_o, 0);
        check("clr async count", ifa.press_count_o, 0);
        repeat (2) @(negedge clk);
        clr = 1'b0;
        drive(1, 6);
        check("post-clr press_count", ifa.press_count_o, 1);
        check("post-clr held", ifa.held_o, 1);
        drive(0, 8);
        check("post-clr release count", nrel[0] - s_rel[0], 1);

        // 256 short taps wrap the counter back to zero.
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        drive(0, 2);
        snap();
        for (int i = 0; i < 256; i++) begin
            drive(1, 3);
            drive(0, 3);
        end
        drive(0, 8);
        check("wrap press pulses", npress[0] - s_press[0], 256);
        check("wrap release pulses", nrel[0] - s_rel[0], 256);
        check("wrap press pulses b", npress[1] - s_press[1], 256);
        check("wrap press_count", ifa.press_count_o, 0);

        check("dut_a events outstanding", qa.size(), 0);
        check("dut_b events outstanding", qb.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule
